rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Round-robin arbiter that shares one downstream resource among eight requesters. It holds a registered grant pointer and drives a one-hot grant vector through a 3:8 decode of that pointer. Fairness comes from rotating the search start past the last winner. It sits between the eight requester front-ends and the shared datapath; `gnt_id` is the datapath's select input and `gnt` is the per-requester acknowledge.

## Interface
- `MAX_HOLD`, 16: maximum consecutive grant cycles per tenure; legal range 2..255; only meaningful with `ARB_TIMEOUT_EN`.
- `HOLD_W`, 8: width of the hold counter; must satisfy 2^`HOLD_W` > `MAX_HOLD`.
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `req`, input, 8: per-requester request level; bit i belongs to requester i.
- `gnt`, output, 8: one-hot grant, registered; all-zero when no grant.
- `gnt_id`, output, 3: index of the current grantee; valid only when `gnt_vld`=1.
- `gnt_vld`, output, 1: high exactly when `gnt` is non-zero.
- `busy`, output, 1: high in GRANT and RELEASE states.

## Operation
- FSM states: IDLE, GRANT, RELEASE.
- **IDLE**
  - With `req`=0, stay in IDLE.
  - Otherwise select the first set `req` bit scanning `ptr`, `ptr`+1, …, wrapping 7→0.
  - Load the winner into `gnt_id` and go to GRANT.
- **GRANT**
  - `gnt` = decode(`gnt_id`) and `gnt_vld`=1.
  - The hold counter increments every cycle, starting at 0 on entry.
  - Stay while `req[gnt_id]`=1.
  - When `req[gnt_id]`=0 is sampled, go to RELEASE.
- **RELEASE**
  - One dead cycle: `gnt`=0, `gnt_vld`=0.
  - `ptr` ← `gnt_id`+1 (mod 8; 7 wraps to 0).
  - Hold counter clears.
  - Go to IDLE.
- Requests from other requesters during GRANT are ignored until re-arbitration. Requests are not latched; a pulse that has dropped before the IDLE scan is lost.
- `gnt_id` keeps its last value outside GRANT. Consumers must qualify it with `gnt_vld`.
- Simultaneous requests are resolved by `ptr` order only; there is no fixed priority.

## Timing
- Reset values: `gnt`=0, `gnt_id`=0, `gnt_vld`=0, `busy`=0, `ptr`=0, hold counter=0, state=IDLE.
- Assertion of `rst` clears all outputs immediately, without waiting for `clk`, including in the middle of a grant.
- Grant latency: `req` sampled in IDLE at edge N gives `gnt` high after edge N+1. That is 1 cycle, registered.
- Release latency: `req[gnt_id]` low at edge N gives `gnt` low after edge N+1. The next grant is issued no earlier than after edge N+3.
- Minimum tenure is 1 cycle. Back-to-back grants are always separated by at least one RELEASE cycle and one IDLE cycle.

## Configuration
- Macro: `ARB_TIMEOUT_EN`.
- **Defined**
  - When the hold counter reaches `MAX_HOLD`-1 in GRANT, go to RELEASE even if `req[gnt_id]` is still 1.
  - This caps the tenure at exactly `MAX_HOLD` cycles.
  - `ptr` advances normally, so another active requester wins next.
  - If the preempted requester is the only one still requesting, it is re-granted after the RELEASE and IDLE cycles.
- **Undefined**
  - The hold counter and the `MAX_HOLD` compare are not built.
  - A grant lasts until the requester drops `req`.
  - `MAX_HOLD` and `HOLD_W` are accepted but unused.

## Structure
- Shared package/include `arb_defs`:
  - state encodings: IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2
  - requester count 8 and index width 3
- One sub-module, `grant_dec3_8`: combinational 3:8 one-hot decode with enable.
  - Inputs are `gnt_id` and the GRANT-state flag.
  - Its output is registered into `gnt` by the top level.
- The rotating priority scan stays in the top level.

## Test plan
- **Reset mid-grant:** `req`=8'h01 granted (`gnt`=8'h01), then assert `rst` between edges → `gnt`=0, `gnt_vld`=0 with no wait for `clk`; after release, `ptr`=0.
- **Single request:** `req`=8'h04 from IDLE → next cycle `gnt`=8'h04, `gnt_id`=2. Drop `req` → `gnt`=0 one cycle later.
- **Rotation:** `req`=8'hFF held, each requester drops after 3 granted cycles and re-raises during RELEASE → grant order 0,1,2,…,7,0, with two idle-gap cycles between tenures.
- **Wrap-around:** last grant id 7 (`ptr`=0), then `req`=8'h81 → requester 0 wins. After it releases (`ptr`=1), requester 7 wins.
- **Timeout (`ARB_TIMEOUT_EN`, `MAX_HOLD`=4):** `req`=8'h03 held → requester 0 granted exactly 4 cycles, then requester 1 for 4 cycles, alternating. Without the macro, requester 0 keeps the grant indefinitely.

Source files
------------

// File: rtl/arb_defs_pkg.sv
// Shared definitions for the rr_arbiter8 slice: FSM state encodings and requester geometry.
package arb_defs;

   localparam int unsigned NREQ  = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/grant_dec3_8.sv
// Combinational 3:8 one-hot decode with enable; feeds the registered grant vector.
module grant_dec3_8
   import arb_defs::*;
(
   input  logic [IDX_W-1:0] id_i,
   input  logic             en_i,
   output logic [NREQ-1:0]  onehot_o
);

   always_comb begin
      onehot_o = '0;
      if (en_i) begin
         onehot_o[id_i] = 1'b1;
      end
   end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with registered one-hot grant and a RELEASE dead cycle.
// Optional tenure cap on MAX_HOLD cycles is built only when ARB_TIMEOUT_EN is defined.
module rr_arbiter8
   import arb_defs::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned HOLD_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   output logic [NREQ-1:0]  gnt,
   output logic [IDX_W-1:0] gnt_id,
   output logic             gnt_vld,
   output logic             busy
);

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
   logic [NREQ-1:0]  gnt_q;
   logic             gnt_vld_q;
   logic [NREQ-1:0]  dec_onehot;
   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] scan_idx;
   logic             found;

`ifdef ARB_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_q, hold_d;
`else
   logic [HOLD_W-1:0] unused_hold_cfg;
   assign unused_hold_cfg = HOLD_W'(MAX_HOLD);
`endif

   // Rotating scan: index arithmetic is IDX_W wide so ptr+k wraps 7->0 naturally.
   always_comb begin
      winner   = ptr_q;
      scan_idx = ptr_q;
      found    = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = ptr_q + IDX_W'(k);
         if (!found && req[scan_idx]) begin
            winner = scan_idx;
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      gnt_id_d = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
      hold_d   = hold_q;
`endif
      case (state_q)
         IDLE: begin
            if (found) begin
               state_d  = GRANT;
               gnt_id_d = winner;
            end
         end
         GRANT: begin
`ifdef ARB_TIMEOUT_EN
            hold_d = hold_q + HOLD_W'(1);
            if (!req[gnt_id_q] || (hold_q == HOLD_W'(MAX_HOLD - 1))) begin
               state_d = RELEASE;
            end
`else
            if (!req[gnt_id_q]) begin
               state_d = RELEASE;
            end
`endif
         end
         RELEASE: begin
            ptr_d   = gnt_id_q + IDX_W'(1);
            state_d = IDLE;
`ifdef ARB_TIMEOUT_EN
            hold_d  = '0;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // Decode the next state/id so the registered grant lines up with the GRANT state.
   grant_dec3_8 u_dec (
      .id_i     (gnt_id_d),
      .en_i     (state_d == GRANT),
      .onehot_o (dec_onehot)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gnt_id_q  <= '0;
         gnt_q     <= '0;
         gnt_vld_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         hold_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_id_q  <= gnt_id_d;
         gnt_q     <= dec_onehot;
         gnt_vld_q <= (state_d == GRANT);
`ifdef ARB_TIMEOUT_EN
         hold_q    <= hold_d;
`endif
      end
   end

   assign gnt     = gnt_q;
   assign gnt_id  = gnt_id_q;
   assign gnt_vld = gnt_vld_q;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: directed scenarios plus random requests against a tenure-level model.
module tb_rr_arbiter8;

   localparam int unsigned TB_MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TIMEOUT = 1'b1;
`else
   localparam bit TIMEOUT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_vld;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: current owner (-1 none), last winner, rotate start, dead cycles left, cycles held.
   int m_owner, m_last, m_ptr, m_cool, m_tenure;

   rr_arbiter8 #(.MAX_HOLD(TB_MAX_HOLD), .HOLD_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_vld (gnt_vld),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_owner  = -1;
      m_last   = 0;
      m_ptr    = 0;
      m_cool   = 0;
      m_tenure = 0;
   endtask

   task automatic model_step(input logic [7:0] r);
      if (m_owner >= 0) begin
         m_tenure++;
         if (!r[m_owner] || (TIMEOUT && m_tenure >= TB_MAX_HOLD)) begin
            m_ptr   = (m_owner + 1) % 8;
            m_owner = -1;
            m_cool  = 1;
         end
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (r != 8'h00) begin
         for (int k = 0; k < 8; k++) begin
            int i;
            i = (m_ptr + k) % 8;
            if (m_owner < 0 && r[i]) begin
               m_owner  = i;
               m_last   = i;
               m_tenure = 0;
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".gnt"},     32'(gnt),     (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk({tag, ".gnt_id"},  32'(gnt_id),  32'(m_last));
      chk({tag, ".gnt_vld"}, 32'(gnt_vld), (m_owner >= 0) ? 32'd1 : 32'd0);
      chk({tag, ".busy"},    32'(busy),    (m_owner >= 0 || m_cool > 0) ? 32'd1 : 32'd0);
   endtask

   task automatic cycle(input logic [7:0] r, input string tag);
      req = r;
      @(posedge clk);
      model_step(r);
      @(negedge clk);
      check_all(tag);
   endtask

   // Called at a falling edge: assert reset between edges and check outputs before any clock.
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_async.gnt", 32'(gnt), 32'd0);
      chk("rst_async.vld", 32'(gnt_vld), 32'd0);
      check_all("rst_async");
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      req = 8'h00;
   endtask

   initial begin
      logic [7:0] r;
      int         order_n;
      int         gap;
      logic       prev_vld;
      int         ten_id[$];
      int         ten_len[$];

      rst = 1'b1;
      req = 8'h00;
      model_reset();
      repeat (2) @(negedge clk);
      check_all("reset");
      rst = 1'b0;

      // Single request
      cycle(8'h04, "single");
      chk("single_gnt", 32'(gnt), 32'h04);
      chk("single_id", 32'(gnt_id), 32'd2);
      cycle(8'h04, "single");
      cycle(8'h00, "single");
      chk("single_drop", 32'(gnt), 32'h00);
      cycle(8'h00, "single");
      cycle(8'h00, "single");

      // Reset in the middle of a grant
      cycle(8'h01, "rmg");
      cycle(8'h01, "rmg");
      chk("rmg_pre", 32'(gnt), 32'h01);
      do_reset();

      // Rotation: everyone requests, each holder drops in its third cycle
      order_n  = 0;
      gap      = 0;
      prev_vld = 1'b0;
      for (int c = 0; c < 200 && order_n < 9; c++) begin
         r = 8'hFF;
         if (m_owner >= 0 && m_tenure == 2) r[m_owner] = 1'b0;
         cycle(r, "rot");
         if (gnt_vld && !prev_vld) begin
            chk("rot_order", 32'(gnt_id), 32'(order_n % 8));
            if (order_n > 0) chk("rot_gap", 32'(gap), 32'd2);
            order_n++;
         end
         gap      = gnt_vld ? 0 : gap + 1;
         prev_vld = gnt_vld;
      end
      chk("rot_count", 32'(order_n), 32'd9);
      repeat (3) cycle(8'h00, "rot_tail");

      // Wrap-around
      cycle(8'h80, "wrap");
      chk("wrap_pre", 32'(gnt_id), 32'd7);
      cycle(8'h00, "wrap");
      cycle(8'h00, "wrap");
      cycle(8'h81, "wrap");
      chk("wrap_0", 32'(gnt), 32'h01);
      cycle(8'h80, "wrap");
      cycle(8'h80, "wrap");
      cycle(8'h80, "wrap");
      chk("wrap_7", 32'(gnt_id), 32'd7);
      repeat (3) cycle(8'h00, "wrap_tail");

      // Two persistent requesters: tenure cap or indefinite hold
      prev_vld = 1'b0;
      for (int c = 0; c < 30; c++) begin
         cycle(8'h03, "hold");
         if (gnt_vld && !prev_vld) begin
            ten_id.push_back(int'(gnt_id));
            ten_len.push_back(1);
         end else if (gnt_vld && ten_len.size() > 0) begin
            ten_len[ten_len.size()-1] = ten_len[ten_len.size()-1] + 1;
         end
         prev_vld = gnt_vld;
      end
`ifdef ARB_TIMEOUT_EN
      chk("to_ntenures", 32'(ten_id.size() >= 3), 32'd1);
      if (ten_id.size() >= 3) begin
         chk("to_id0", 32'(ten_id[0]), 32'd0);
         chk("to_len0", 32'(ten_len[0]), 32'd4);
         chk("to_id1", 32'(ten_id[1]), 32'd1);
         chk("to_len1", 32'(ten_len[1]), 32'd4);
         chk("to_id2", 32'(ten_id[2]), 32'd0);
      end
`else
      chk("hold_ntenures", 32'(ten_id.size()), 32'd1);
      chk("hold_id", 32'(gnt_id), 32'd0);
      chk("hold_vld", 32'(gnt_vld), 32'd1);
`endif
      repeat (3) cycle(8'h00, "hold_tail");

      // Random traffic with occasional asynchronous resets
      r = 8'h00;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(3) == 0) begin
            r = 8'($urandom) & 8'($urandom);
         end else if ($urandom_range(5) == 0) begin
            r[$urandom_range(7)] = ~r[$urandom_range(7)];
         end
         cycle(r, "rand");
         if (c % 997 == 500) do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
